md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide responder for the 5-stage pipeline; owns the HI/LO registers.
- The Execution stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a start/op handshake.
- The unit answers with busy/done, and HI/LO are read back for MFHI/MFLO.
- The hazard controller uses start|busy to stall MD-class instructions in Decode.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request valid for one cycle; sampled on the rising edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; HI/LO were updated at this edge by a mult/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset:
  - Applies at any edge where reset==0, including mid-operation. The in-flight operation is discarded.
  - Afterwards: busy=0, done=0, hi=0, lo=0, counter=0, state=IDLE.
- States: IDLE and RUN.
- IDLE, start=1, op in 0..3:
  - Operands are latched, the result is computed into pending_hi/pending_lo, and the unit enters RUN.
  - counter loads MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3). busy=1 from the next cycle.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, done<=1 for exactly one cycle, return to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO are visible in the first cycle after busy falls.
- done is 0 in every other cycle.
- IDLE, start=1, op=4: hi<=A on that edge, no busy, no done. op=5: lo<=A likewise.
- start=1 with op 6/7: ignored.
- start=1 while busy=1: ignored for every op, including MTHI/MTLO; state and HI/LO are unchanged. The hazard controller guarantees this never occurs. The bench checks that it is ignored.
- MULT: signed 32x32 to 64 bits; hi=upper 32 bits, lo=lower 32 bits. MULTU: the unsigned equivalent.
- DIV (signed):
  - lo=quotient, truncated toward zero; hi=remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (either divide op): lo=0xFFFFFFFF, hi=A. Normal busy/done timing still applies.
- Back-to-back: a start sampled in the same cycle done is high is accepted (state is already IDLE), so there is no dead cycle.
- Outputs are registers only; no combinational path from inputs to hi/lo/busy/done.

Test Plan:
- Reset then MULT: A=0xFFFFFFFE (-2), B=3.
  - busy high for 5 cycles, done pulses once.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF.
  - After 5 busy cycles: hi=0xFFFFFFFE, lo=0x00000001.
- DIV: A=-7 (0xFFFFFFF9), B=2.
  - busy high for 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with B=0: A=0x12345678.
  - busy high for 10 cycles, done pulses.
  - lo=0xFFFFFFFF, hi=0x12345678.
- MTHI then MTLO:
  - MTHI A=0xAAAA5555 with no busy: hi=0xAAAA5555 next cycle.
  - MTLO issued during a following MULT's busy: ignored, lo takes the MULT result.
- Reset pulled low at busy cycle 3 of a DIV:
  - Next cycle: busy=0, done stays 0, hi=lo=0.
  - A subsequent MULT 3x4 gives lo=12, hi=0.

Source files
------------

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide responder that owns the HI/LO registers.
// The Execution stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a one-cycle
// start/op handshake. Mult/div results are computed when the request is
// accepted and held in pending registers. They are committed to HI/LO after
// a fixed busy period so that the pipeline sees the architectural latency.
//
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   synchronous active-low reset
//   start  in   1   request valid (single cycle)
//   op     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   A      in  32   rs operand
//   B      in  32   rt operand
//   busy   out  1   mult/div in flight
//   done   out  1   one-cycle pulse, HI/LO were just written by a mult/div
//   hi     out 32   HI register
//   lo     out 32   LO register
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,   // 1..15
    parameter int DIV_CYCLES  = 10   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] L_MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] L_DIV_N  = DIV_CYCLES[3:0];

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ---------------- multiply ----------------
    // The low 64 bits of a product of sign-extended operands equal the
    // signed 32x32 product, so both flavours share the same 64-bit multiply.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // ---------------- divide ----------------
    // A single unsigned divider serves both ops. Signed division divides
    // magnitudes and then restores the signs: the quotient is negative when
    // the operand signs differ, and the remainder follows the dividend.
    // |0x80000000| = 0x80000000 is still correct as an unsigned magnitude,
    // so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    logic        w_is_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic        w_div_zero;

    assign w_is_signed = (op == 3'd2);
    assign w_a_neg     = w_is_signed & A[31];
    assign w_b_neg     = w_is_signed & B[31];
    assign w_dvd       = w_a_neg ? (~A + 32'd1) : A;
    assign w_dvs       = w_b_neg ? (~B + 32'd1) : B;
    assign w_div_zero  = (B == 32'd0);
    // Divisor forced to 1 on divide-by-zero keeps the divider well defined;
    // its output is overridden below in that case anyway.
    assign w_q_mag     = w_dvd / (w_div_zero ? 32'd1 : w_dvs);
    assign w_r_mag     = w_dvd % (w_div_zero ? 32'd1 : w_dvs);
    assign w_div_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_div_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ---------------- result select ----------------
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (op)
            3'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            3'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            3'd2, 3'd3: begin
                if (w_div_zero) begin
                    w_res_hi = A;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_div_r;
                    w_res_lo = w_div_q;
                end
            end
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_count   <= L_MULT_N;
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            3'd2, 3'd3: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_count   <= L_DIV_N;
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            3'd4:    r_hi <= A;
                            3'd5:    r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // Requests arriving here are dropped; the hazard logic
                    // never issues them, but they must not disturb state.
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
